conv_layer_sequencer: RTL and testbench

CONV_LAYER_SEQUENCER -- requirements
Module: conv_layer_sequencer

---
 rtl/conv_layer_sequencer.sv | 160 ++++++++++++++++
 tb/tb_conv_layer_sequencer.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/conv_layer_sequencer.sv
// Convolution layer sequencer: latches and validates a layer config, streams pixels into
// the window FIFO, issues one window read per cycle and indexes the returning results.
module conv_layer_sequencer #(
    parameter int ADDR_BIT = 10,
    parameter int CNT_W    = 22
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic [ADDR_BIT:0] cfg_row_len,
    input  logic [ADDR_BIT:0] cfg_rows,
    input  logic [2:0]        cfg_stride,
    input  logic              pix_vld,
    output logic              pix_rdy,
    output logic              ff_wen,
    output logic              ff_ren,
    input  logic              ff_load_done,
    input  logic              ff_empty,
    input  logic              ff_full,
    input  logic              entry_vld,
    output logic              out_vld,
    output logic [ADDR_BIT:0] out_col,
    output logic [ADDR_BIT:0] out_row,
    output logic              busy,
    output logic              done,
    output logic              err
);
    localparam int AW = ADDR_BIT + 1;
    localparam int PW = 2 * AW;
    localparam int MW = (CNT_W > PW) ? CNT_W : PW;

    typedef enum logic [2:0] {IDLE, CHECK, RUN, DRAIN, DONE} state_t;

    state_t           state_q, state_d;
    logic [AW-1:0]    row_len_q, row_len_d, rows_q, rows_d, ow_q, ow_d;
    logic [AW-1:0]    out_col_q, out_col_d, out_row_q, out_row_d;
    logic [2:0]       stride_q, stride_d;
    logic [PW-1:0]    total_q, total_d, npix_q, npix_d;
    logic [CNT_W-1:0] pix_cnt_q, pix_cnt_d, rd_cnt_q, rd_cnt_d, out_cnt_q, out_cnt_d;
    logic             err_q, err_d;

    logic [AW-1:0] ow_c, oh_c;
    logic          cfg_ok, run, pix_rdy_c, ff_wen_c, ff_ren_c, out_vld_c;

    // Stride is restricted to 1 or 2, so the divide collapses to an optional shift.
    assign cfg_ok = ((stride_q == 3'd1) || (stride_q == 3'd2)) &&
                    (row_len_q >= AW'(3)) && (rows_q >= AW'(3));
    assign ow_c   = ((stride_q == 3'd2) ? ((row_len_q - AW'(3)) >> 1) : (row_len_q - AW'(3))) + AW'(1);
    assign oh_c   = ((stride_q == 3'd2) ? ((rows_q - AW'(3)) >> 1) : (rows_q - AW'(3))) + AW'(1);

    // Handshakes are masked during rst so nothing reaches the FIFO on the reset cycle.
    assign run       = (state_q == RUN) && !rst;
    assign pix_rdy_c = run && !ff_full && (MW'(pix_cnt_q) < MW'(npix_q));
    assign ff_wen_c  = pix_vld && pix_rdy_c;
    assign ff_ren_c  = run && ff_load_done && !ff_empty && (MW'(rd_cnt_q) < MW'(total_q));
    assign out_vld_c = !rst && ((state_q == RUN) || (state_q == DRAIN)) && entry_vld;

    assign pix_rdy = pix_rdy_c;
    assign ff_wen  = ff_wen_c;
    assign ff_ren  = ff_ren_c;
    assign out_vld = out_vld_c;
    assign out_col = out_col_q;
    assign out_row = out_row_q;
    assign busy    = !rst && (state_q inside {CHECK, RUN, DRAIN});
    assign done    = !rst && (state_q == DONE);
    assign err     = !rst && err_q;

    always_comb begin
        // NOTE: every _d gets its hold value first so no path through the case leaves a latch.
        state_d   = state_q;
        row_len_d = row_len_q;
        rows_d    = rows_q;
        stride_d  = stride_q;
        ow_d      = ow_q;
        total_d   = total_q;
        npix_d    = npix_q;
        err_d     = err_q;
        out_col_d = out_col_q;
        out_row_d = out_row_q;
        pix_cnt_d = pix_cnt_q + CNT_W'(ff_wen_c);
        rd_cnt_d  = rd_cnt_q + CNT_W'(ff_ren_c);
        out_cnt_d = out_cnt_q + CNT_W'(out_vld_c);

        if (out_vld_c) begin
            if (out_col_q == ow_q - AW'(1)) begin
                out_col_d = '0;
                out_row_d = out_row_q + AW'(1);
            end else begin
                out_col_d = out_col_q + AW'(1);
            end
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    row_len_d = cfg_row_len;
                    rows_d    = cfg_rows;
                    stride_d  = cfg_stride;
                    pix_cnt_d = '0;
                    rd_cnt_d  = '0;
                    out_cnt_d = '0;
                    out_col_d = '0;
                    out_row_d = '0;
                    state_d   = CHECK;
                end
            end
            CHECK: begin
                ow_d    = ow_c;
                total_d = PW'(ow_c) * PW'(oh_c);
                npix_d  = PW'(row_len_q) * PW'(rows_q);
                err_d   = !cfg_ok;
                state_d = cfg_ok ? RUN : IDLE;
            end
            RUN: begin
                if ((MW'(rd_cnt_d) == MW'(total_q)) && (MW'(pix_cnt_d) == MW'(npix_q)))
                    state_d = DRAIN;
            end
            DRAIN: begin
                // Results can already be complete on entry when pixels finished last.
                if (MW'(out_cnt_d) >= MW'(total_q))
                    state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments only, so every flop samples the pre-edge _d values.
        if (rst) begin
            state_q   <= IDLE;
            row_len_q <= '0;
            rows_q    <= '0;
            stride_q  <= '0;
            ow_q      <= '0;
            total_q   <= '0;
            npix_q    <= '0;
            err_q     <= 1'b0;
            out_col_q <= '0;
            out_row_q <= '0;
            pix_cnt_q <= '0;
            rd_cnt_q  <= '0;
            out_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            row_len_q <= row_len_d;
            rows_q    <= rows_d;
            stride_q  <= stride_d;
            ow_q      <= ow_d;
            total_q   <= total_d;
            npix_q    <= npix_d;
            err_q     <= err_d;
            out_col_q <= out_col_d;
            out_row_q <= out_row_d;
            pix_cnt_q <= pix_cnt_d;
            rd_cnt_q  <= rd_cnt_d;
            out_cnt_q <= out_cnt_d;
        end
    end
endmodule

// File: tb/tb_conv_layer_sequencer.sv
// Self-checking bench: scoreboard of expected (row,col) outputs plus per-layer
// write/read/done counts, a simple window-FIFO model and a 3-cycle psum delay line.
module tb_conv_layer_sequencer;
    localparam int AB = 10;
    localparam int AW = AB + 1;

    logic          clk = 1'b0, rst = 1'b1, start = 1'b0, pix_vld = 1'b0;
    logic [AW-1:0] cfg_row_len = '0, cfg_rows = '0;
    logic [2:0]    cfg_stride = '0;
    logic          pix_rdy, ff_wen, ff_ren, ff_load_done, ff_empty, ff_full, entry_vld;
    logic          out_vld, busy, done, err;
    logic [AW-1:0] out_col, out_row;

    typedef struct {int row; int col;} pos_t;
    pos_t sb_q[$];

    int   n_checks = 0, n_errors = 0;
    int   wen_cnt = 0, ren_cnt = 0, out_cnt = 0, done_cnt = 0;
    int   tb_wr = 0, cur_rl = 3;
    bit   full_force = 1'b0, full_rand = 1'b0;
    logic [2:0] sr = '0;

    conv_layer_sequencer #(.ADDR_BIT(AB), .CNT_W(22)) dut (
        .clk(clk), .rst(rst), .start(start),
        .cfg_row_len(cfg_row_len), .cfg_rows(cfg_rows), .cfg_stride(cfg_stride),
        .pix_vld(pix_vld), .pix_rdy(pix_rdy), .ff_wen(ff_wen), .ff_ren(ff_ren),
        .ff_load_done(ff_load_done), .ff_empty(ff_empty), .ff_full(ff_full),
        .entry_vld(entry_vld), .out_vld(out_vld), .out_col(out_col), .out_row(out_row),
        .busy(busy), .done(done), .err(err)
    );

    always #5 clk = ~clk;

    // Window-FIFO model: windows become readable once three image rows are stored.
    always @(posedge clk) begin
        if (rst || !busy) tb_wr <= 0;
        else if (ff_wen)  tb_wr <= tb_wr + 1;
        if (rst) sr <= '0;
        else     sr <= {sr[1:0], ff_ren};
    end
    assign ff_load_done = (tb_wr >= 3 * cur_rl);
    assign ff_empty     = (tb_wr == 0);
    assign ff_full      = full_force | full_rand;
    assign entry_vld    = sr[2];

    task automatic check(input string name, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, got, exp, $time);
        end
    endtask

    // Monitor: pops the scoreboard on every result and tallies handshakes.
    always @(negedge clk) begin
        if (!rst) begin
            if (ff_wen) wen_cnt++;
            if (ff_ren) ren_cnt++;
            if (done)   done_cnt++;
            if (full_force) begin
                check("full_pix_rdy", int'(pix_rdy), 0);
                check("full_ff_wen", int'(ff_wen), 0);
            end
            if (out_vld) begin
                out_cnt++;
                if (sb_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL out_unexpected: got (%0d,%0d) expected no output", out_row, out_col);
                end else begin
                    pos_t e;
                    e = sb_q.pop_front();
                    check("out_row", int'(out_row), e.row);
                    check("out_col", int'(out_col), e.col);
                end
            end
        end
    end

    task automatic expect_layer(input int rl, input int rw, input int st);
        int ow, oh;
        ow = (rl - 3) / st + 1;
        oh = (rw - 3) / st + 1;
        for (int r = 0; r < oh; r++)
            for (int c = 0; c < ow; c++)
                sb_q.push_back('{row: r, col: c});
        cur_rl  = rl;
        wen_cnt = 0; ren_cnt = 0; out_cnt = 0; done_cnt = 0;
    endtask

    task automatic pulse_start(input int rl, input int rw, input int st);
        @(posedge clk); #1;
        cfg_row_len = AW'(rl); cfg_rows = AW'(rw); cfg_stride = 3'(st);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        // Scramble the inputs so only the latched copy can be in use.
        cfg_row_len = AW'($urandom_range(0, 40));
        cfg_rows    = AW'($urandom_range(0, 40));
        cfg_stride  = 3'($urandom_range(0, 7));
    endtask

    task automatic run_layer(input int rl, input int rw, input int st,
                             input bit rnd, input bit full_burst, input bit busy_start);
        int cyc;
        int ow, oh;
        ow = (rl - 3) / st + 1;
        oh = (rw - 3) / st + 1;
        expect_layer(rl, rw, st);
        pulse_start(rl, rw, st);
        @(posedge clk); #1;
        check("run_err_clear", int'(err), 0);
        check("run_busy", int'(busy), 1);
        cyc = 0;
        while (done_cnt == 0 && cyc < 4000) begin
            pix_vld    = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            full_rand  = rnd && ($urandom_range(0, 7) == 0);
            full_force = full_burst && (cyc >= 8) && (cyc < 18);
            start      = busy_start && (cyc == 12);
            if (start) begin
                cfg_row_len = AW'(3); cfg_rows = AW'(3); cfg_stride = 3'd1;
            end
            @(posedge clk); #1;
            cyc++;
        end
        start = 1'b0; pix_vld = 1'b0; full_rand = 1'b0; full_force = 1'b0;
        check("layer_timeout", (cyc < 4000) ? 1 : 0, 1);
        repeat (4) @(posedge clk);
        #1;
        check("wen_count", wen_cnt, rl * rw);
        check("ren_count", ren_cnt, ow * oh);
        check("out_count", out_cnt, ow * oh);
        check("done_pulses", done_cnt, 1);
        check("sb_left", sb_q.size(), 0);
        check("idle_busy", int'(busy), 0);
        check("idle_err", int'(err), 0);
    endtask

    task automatic bad_start(input int rl, input int rw, input int st);
        wen_cnt = 0; ren_cnt = 0;
        pix_vld = 1'b1;
        pulse_start(rl, rw, st);
        check("bad_busy_check", int'(busy), 1);
        @(posedge clk); #1;
        check("bad_err", int'(err), 1);
        check("bad_busy", int'(busy), 0);
        repeat (4) @(posedge clk);
        #1;
        check("bad_wen", wen_cnt, 0);
        check("bad_ren", ren_cnt, 0);
        check("bad_err_sticky", int'(err), 1);
        pix_vld = 1'b0;
    endtask

    task automatic reset_mid_run();
        int cyc;
        expect_layer(5, 5, 1);
        pulse_start(5, 5, 1);
        pix_vld = 1'b1;
        cyc = 0;
        while (out_cnt < 4 && cyc < 500) begin
            @(posedge clk); #1;
            cyc++;
        end
        check("rst_wait_timeout", (cyc < 500) ? 1 : 0, 1);
        check("busy_before_rst", int'(busy), 1);
        rst = 1'b1;
        sb_q.delete();
        @(negedge clk);
        check("rst_no_wen", int'(ff_wen), 0);
        check("rst_no_ren", int'(ff_ren), 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("post_rst_row", int'(out_row), 0);
        check("post_rst_col", int'(out_col), 0);
        check("post_rst_busy", int'(busy), 0);
        check("post_rst_wen", int'(ff_wen), 0);
        check("post_rst_ren", int'(ff_ren), 0);
        check("post_rst_rdy", int'(pix_rdy), 0);
        check("post_rst_out_vld", int'(out_vld), 0);
        pix_vld = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check("reset_pix_rdy", int'(pix_rdy), 0);
        check("reset_ff_wen", int'(ff_wen), 0);
        check("reset_ff_ren", int'(ff_ren), 0);
        check("reset_out_vld", int'(out_vld), 0);
        check("reset_busy", int'(busy), 0);
        check("reset_done", int'(done), 0);
        check("reset_err", int'(err), 0);
        check("reset_out_row", int'(out_row), 0);
        check("reset_out_col", int'(out_col), 0);
        rst = 1'b0;

        run_layer(5, 5, 1, 1'b0, 1'b0, 1'b0);
        run_layer(7, 7, 2, 1'b0, 1'b0, 1'b0);
        run_layer(6, 5, 1, 1'b0, 1'b1, 1'b0);
        bad_start(5, 5, 3);
        run_layer(5, 6, 1, 1'b0, 1'b0, 1'b1);
        bad_start(2, 5, 1);
        run_layer(4, 4, 2, 1'b0, 1'b0, 1'b0);
        reset_mid_run();
        run_layer(5, 5, 1, 1'b0, 1'b0, 1'b0);

        for (int i = 0; i < 6; i++) begin
            int rl, rw, st;
            rl = $urandom_range(3, 12);
            rw = $urandom_range(3, 12);
            st = $urandom_range(1, 2);
            run_layer(rl, rw, st, 1'b1, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
